// File: rtl/ssrv_wb_pkg.sv
// ssrv_wb_pkg: shared types and constants for the core-to-Wishbone bridge.
//   mem_width_e    : encoding of the core access width (2'b11 is reserved)
//   bridge_state_e : bridge FSM states
//   SEL_*          : base byte-strobe patterns before lane shifting
package ssrv_wb_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } bridge_state_e;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/ssrv_lane_align.sv
// ssrv_lane_align: purely combinational byte-lane handling.
// Request side (from the live core payload):
//   width, addr_lo, wdata   -> sel, wdata_rep, illegal
// Read side (from the latched payload and the bus word):
//   rd_width, rd_addr_lo, rd_word -> rd_data (right-aligned, zero-extended)
import ssrv_wb_pkg::*;

module ssrv_lane_align (
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic        illegal,
    input  logic [1:0]  rd_width,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] rd_shifted;

    always_comb begin
        sel       = 4'b0000;
        wdata_rep = wdata;
        illegal   = 1'b0;
        case (width)
            MEM_BYTE: begin
                sel       = SEL_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
                sel       = SEL_HALF << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                illegal   = addr_lo[0];
            end
            MEM_WORD: begin
                sel       = SEL_WORD;
                illegal   = |addr_lo;
            end
            default: illegal = 1'b1;   // reserved width encoding
        endcase
    end

    always_comb begin
        rd_shifted = rd_word >> {rd_addr_lo, 3'b000};
        case (rd_width)
            MEM_BYTE: rd_data = {24'h0, rd_shifted[7:0]};
            MEM_HALF: rd_data = {16'h0, rd_shifted[15:0]};
            default:  rd_data = rd_shifted;
        endcase
    end

endmodule

// File: rtl/ssrv_wb_bridge.sv
// ssrv_wb_bridge: converts the core request/response memory port into a
// single-outstanding Wishbone-classic master cycle. All outputs registered.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   req/cmd/width/addr/wdata       : core request (held until resp)
//   rdata/resp/err                 : core response (resp is a 1-cycle pulse)
//   wb_cyc/wb_stb/wb_we/wb_sel/wb_addr/wb_dat_o : Wishbone master outputs
//   wb_dat_i/wb_ack                : Wishbone slave returns
// Optional feature: define SSRV_WB_TIMEOUT_EN to abort a bus cycle with err
// after TIMEOUT_CYCLES cycles without wb_ack.
import ssrv_wb_pkg::*;

module ssrv_wb_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              cmd,
    input  logic [1:0]        width,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              resp,
    output logic              err,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [3:0]        wb_sel,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("ssrv_wb_bridge supports DATA_W = 32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ssrv_wb_bridge needs TIMEOUT_CYCLES >= 1");
    end

    bridge_state_e     state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [1:0]        width_q, width_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_q, resp_d;
    logic              err_q, err_d;

    logic [3:0]        req_sel;
    logic [31:0]       req_wdata;
    logic              req_illegal;
    logic [31:0]       rd_aligned;
    logic              tmo_expired;

    ssrv_lane_align u_lane (
        .width      (width),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .sel        (req_sel),
        .wdata_rep  (req_wdata),
        .illegal    (req_illegal),
        .rd_width   (width_q),
        .rd_addr_lo (addr_lo_q),
        .rd_word    (wb_dat_i),
        .rd_data    (rd_aligned)
    );

`ifdef SSRV_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Held at zero outside BUS, so it is already clear on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tmo_cnt_q <= '0;
        else if (state_q != ST_BUS) tmo_cnt_q <= '0;
        else                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    // Counter is TIMEOUT_CYCLES-1 during the last permitted BUS cycle.
    assign tmo_expired = (state_q == ST_BUS) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        waddr_d   = waddr_q;
        wdat_d    = wdat_q;
        width_d   = width_q;
        addr_lo_d = addr_lo_q;
        rdata_d   = rdata_q;
        resp_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_illegal) begin
                        state_d = ST_RESP;
                        resp_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d   = ST_BUS;
                        cyc_d     = 1'b1;
                        we_d      = cmd;
                        sel_d     = req_sel;
                        waddr_d   = {addr[ADDR_W-1:2], 2'b00};
                        wdat_d    = req_wdata;
                        width_d   = width;
                        addr_lo_d = addr[1:0];
                    end
                end
            end
            ST_BUS: begin
                // Ack takes priority over a simultaneous timeout.
                if (wb_ack) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    resp_d  = 1'b1;
                    rdata_d = rd_aligned;
                end else if (tmo_expired) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            waddr_q   <= '0;
            wdat_q    <= '0;
            width_q   <= 2'b00;
            addr_lo_q <= 2'b00;
            rdata_q   <= '0;
            resp_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            waddr_q   <= waddr_d;
            wdat_q    <= wdat_d;
            width_q   <= width_d;
            addr_lo_q <= addr_lo_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    assign wb_cyc   = cyc_q;
    assign wb_stb   = cyc_q;
    assign wb_we    = we_q;
    assign wb_sel   = sel_q;
    assign wb_addr  = waddr_q;
    assign wb_dat_o = wdat_q;
    assign rdata    = rdata_q;
    assign resp     = resp_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ssrv_wb_bridge.sv
// Directed bench for ssrv_wb_bridge. Define SSRV_WB_TIMEOUT_EN to also run
// the watchdog sequence (DUT built with TIMEOUT_CYCLES = 8).
module tb_ssrv_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
    logic        err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_addr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssrv_wb_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cmd      (cmd),
        .width    (width),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .resp     (resp),
        .err      (err),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_addr  (wb_addr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack   (wb_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Legal transaction; ack arrives k cycles after wb_cyc first goes high.
    task automatic txn(input string tag, input logic c, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] wd, input int k,
                       input logic [31:0] busw, input logic [3:0] exp_sel,
                       input logic [31:0] exp_dat, input logic [31:0] exp_rd);
        req = 1'b1; cmd = c; width = w; addr = a; wdata = wd;
        step();
        chk({tag, ".cyc"}, 32'(wb_cyc), 32'd1);
        chk({tag, ".stb"}, 32'(wb_stb), 32'd1);
        chk({tag, ".we"}, 32'(wb_we), 32'(c));
        chk({tag, ".sel"}, 32'(wb_sel), 32'(exp_sel));
        chk({tag, ".addr"}, wb_addr, {a[31:2], 2'b00});
        if (c) chk({tag, ".dat_o"}, wb_dat_o, exp_dat);
        for (int i = 0; i < k; i++) begin
            step();
            chk({tag, ".wait_cyc"}, 32'(wb_cyc), 32'd1);
            chk({tag, ".wait_resp"}, 32'(resp), 32'd0);
        end
        wb_ack = 1'b1; wb_dat_i = busw;
        step();
        wb_ack = 1'b0; wb_dat_i = 32'hFFFF_FFFF;
        chk({tag, ".resp"}, 32'(resp), 32'd1);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".cyc_low"}, 32'(wb_cyc), 32'd0);
        if (!c) chk({tag, ".rdata"}, rdata, exp_rd);
        req = 1'b0;
        step();
        chk({tag, ".resp_pulse"}, 32'(resp), 32'd0);
    endtask

    task automatic illegal(input string tag, input logic [1:0] w, input logic [31:0] a);
        req = 1'b1; cmd = 1'b0; width = w; addr = a; wdata = 32'h1111_2222;
        step();
        chk({tag, ".resp"}, 32'(resp), 32'd1);
        chk({tag, ".err"}, 32'(err), 32'd1);
        chk({tag, ".cyc"}, 32'(wb_cyc), 32'd0);
        chk({tag, ".rdata"}, rdata, 32'h0);
        req = 1'b0;
        step();
        chk({tag, ".resp_pulse"}, 32'(resp), 32'd0);
        chk({tag, ".err_clr"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; cmd = 1'b0; width = 2'b00; addr = '0; wdata = '0;
        wb_dat_i = '0; wb_ack = 1'b0;
        step();
        step();
        chk("rst.resp", 32'(resp), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.cyc", 32'(wb_cyc), 32'd0);
        chk("rst.we", 32'(wb_we), 32'd0);
        chk("rst.sel", 32'(wb_sel), 32'd0);
        chk("rst.addr", wb_addr, 32'h0);
        chk("rst.dat_o", wb_dat_o, 32'h0);
        rst = 1'b0;
        step();

        txn("rd_word", 1'b0, 2'b10, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF);
        txn("wr_byte", 1'b1, 2'b00, 32'h103, 32'h0000_005A, 0, 32'h0, 4'b1000, 32'h5A5A_5A5A, 32'h0);
        txn("rd_half", 1'b0, 2'b01, 32'h102, 32'h0, 0, 32'hABCD_1234, 4'b1100, 32'h0, 32'h0000_ABCD);
        txn("rd_byte", 1'b0, 2'b00, 32'h101, 32'h0, 0, 32'hABCD_1234, 4'b0010, 32'h0, 32'h0000_0012);
        txn("wr_half", 1'b1, 2'b01, 32'h200, 32'h1234_BEEF, 1, 32'h0, 4'b0011, 32'hBEEF_BEEF, 32'h0);
        txn("wr_word", 1'b1, 2'b10, 32'h204, 32'hCAFE_F00D, 2, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0);
        txn("rd_byte3", 1'b0, 2'b00, 32'h307, 32'h0, 0, 32'h89AB_CDEF, 4'b1000, 32'h0, 32'h0000_0089);

        illegal("ill_word", 2'b10, 32'h102);
        illegal("ill_res", 2'b11, 32'h100);
        illegal("ill_half", 2'b01, 32'h101);

        // Spurious ack while idle must not produce a response.
        wb_ack = 1'b1; wb_dat_i = 32'h0BAD_0BAD;
        step();
        wb_ack = 1'b0;
        chk("spur.resp", 32'(resp), 32'd0);
        chk("spur.cyc", 32'(wb_cyc), 32'd0);
        step();
        chk("spur.resp2", 32'(resp), 32'd0);
        txn("rd_late", 1'b0, 2'b10, 32'h400, 32'h0, 5, 32'h1357_9BDF, 4'hF, 32'h0, 32'h1357_9BDF);

        // Reset during BUS drops the cycle without a clock edge.
        req = 1'b1; cmd = 1'b0; width = 2'b10; addr = 32'h500;
        step();
        chk("abort.cyc_before", 32'(wb_cyc), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.cyc_async", 32'(wb_cyc), 32'd0);
        chk("abort.resp", 32'(resp), 32'd0);
        req = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort.no_resp", 32'(resp), 32'd0);
            chk("abort.idle_cyc", 32'(wb_cyc), 32'd0);
        end
        txn("rd_after_rst", 1'b0, 2'b01, 32'h600, 32'h0, 0, 32'h7654_3210, 4'b0011, 32'h0, 32'h0000_3210);

`ifdef SSRV_WB_TIMEOUT_EN
        begin
            int n;
            req = 1'b1; cmd = 1'b0; width = 2'b10; addr = 32'h700;
            step();
            n = 0;
            while (wb_cyc && n < 20) begin
                n++;
                step();
            end
            chk("tmo.bus_cycles", 32'(n), 32'd8);
            chk("tmo.resp", 32'(resp), 32'd1);
            chk("tmo.err", 32'(err), 32'd1);
            chk("tmo.rdata", rdata, 32'h0);
            req = 1'b0;
            step();
            chk("tmo.resp_pulse", 32'(resp), 32'd0);
            txn("tmo.follow", 1'b0, 2'b10, 32'h704, 32'h0, 3, 32'h2468_ACE0, 4'hF, 32'h0, 32'h2468_ACE0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssrv_wb_bridge.md
# ssrv_wb_bridge

Converts the core's native request/response memory port (`req`/`cmd`/`width`/`addr`/`wdata` in, `rdata`/`resp`/`err` out) into a Wishbone-classic master cycle toward the Controller memory bus. Sits between `ssrv_top` and the Controller, with one instance on the instruction port and one on the data port. It owns byte-lane strobe generation, write-data replication, read-data lane alignment and response registration. Only one transaction is outstanding at a time.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Fixed at 32; other values are unsupported.
- `TIMEOUT_CYCLES`, 1024: watchdog limit. Used only when `SSRV_WB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req`  in  1: core request. Held high with stable payload until `resp`.
- `cmd`  in  1: 1 = write, 0 = read.
- `width`  in  2: 2'b00 = byte, 2'b01 = halfword, 2'b10 = word, 2'b11 = reserved.
- `addr`  in  ADDR_W: byte address.
- `wdata`  in  32: write data, right-aligned.
- `rdata`  out  32: read data, right-aligned and zero-extended.
- `resp`  out  1: one-cycle completion pulse.
- `err`  out  1: error qualifier, valid only with `resp`.
- `wb_cyc`, `wb_stb`  out  1: bus cycle and strobe. Always equal.
- `wb_we`  out  1: write enable.
- `wb_sel`  out  4: byte strobes.
- `wb_addr`  out  ADDR_W: bus address, word-aligned (`addr[1:0]` forced to 0).
- `wb_dat_o`  out  32: bus write data.
- `wb_dat_i`  in  32: bus read data.
- `wb_ack`  in  1: bus acknowledge.

## Operation
- The FSM has three states: IDLE, BUS, RESP.
- **IDLE.** If `req` is high and the access is legal: latch cmd/width/addr/wdata and go to BUS.
  - An access is misaligned when it is a halfword with `addr[0]=1` or a word with `addr[1:0]≠0`.
  - Misaligned or reserved-width access: go to RESP with error set. No bus cycle is issued.
- **BUS.** `wb_cyc`/`wb_stb` are high. On `wb_ack`: capture `wb_dat_i` into the read register and go to RESP.
- **RESP.** `resp`=1 for exactly one cycle, then go to IDLE.
- Strobes:
  - byte: 4'b0001 << `addr[1:0]`
  - half: 4'b0011 << {`addr[1]`,0}
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Read data: the captured word is shifted right by 8×`addr[1:0]`, then masked to the access width (zero-extend). Sign extension is the core's job.
- Reset values: `resp`=0, `err`=0, `rdata`=0, `wb_cyc`=`wb_stb`=`wb_we`=0, `wb_sel`=0, `wb_addr`=0, `wb_dat_o`=0, state IDLE.
- Boundary conditions:
  - `wb_ack` outside BUS is ignored.
  - `req` during BUS/RESP is ignored; the payload is already latched.
  - A new `req` is accepted only in IDLE. The earliest accept is the cycle after `resp`.
  - `rst` mid-transaction drops `wb_cyc` asynchronously and aborts without `resp`.
  - `err`=1 (write or read) leaves `rdata` at 0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Cycle T: `req` sampled in IDLE.
- Cycle T+1: `wb_cyc` is high.
- If `wb_ack` arrives in cycle T+1+k (k ≥ 0):
  - `wb_cyc` is low at T+2+k.
  - `resp` is high at T+2+k, with `rdata` valid in the same cycle.
- Minimum latency from `req` to `resp` is 2 cycles.
- Illegal access: `resp`/`err` at T+1.
- Sustained throughput: one transaction per (3+k) cycles.

## Configuration
- **`SSRV_WB_TIMEOUT_EN` defined:**
  - A counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches `TIMEOUT_CYCLES` without `wb_ack`, `wb_cyc` drops and the FSM goes to RESP with `err`=1.
  - An ack in the same cycle as expiry wins: the transaction completes normally with `err`=0.
- **Not defined:** no counter is present. BUS waits indefinitely, and `err` is set only for illegal accesses.

## Structure
- `ssrv_wb_pkg` holds:
  - the width encoding enum: `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`;
  - the FSM state enum;
  - the `SEL_*` constants.
- Sub-module `ssrv_lane_align` is purely combinational and contains:
  - strobe generation;
  - write replication;
  - read shift/mask;
  - the misalignment check.
- The FSM, payload latch and timeout counter live in `ssrv_wb_bridge`.

## Test plan
- Word read at `addr`=0x100; `wb_ack` in the first BUS cycle returns 0xDEADBEEF → `wb_sel`=4'hF, `wb_addr`=0x100, `resp` at T+2, `rdata`=0xDEADBEEF, `err`=0.
- Byte write 0x5A to 0x103 → `wb_sel`=4'b1000, `wb_dat_o`=0x5A5A5A5A, `wb_we`=1, `wb_addr`=0x100.
- Half read at 0x102; bus returns 0xABCD1234 → `rdata`=0x0000ABCD. Byte read at 0x101 from the same word → `rdata`=0x00000012.
- Word read at 0x102 → no `wb_cyc`, `resp`=`err`=1 at T+1. Width 2'b11 gives the same result.
- Ack delayed 5 cycles, with a spurious `wb_ack` pulsed in IDLE beforehand → the spurious ack is ignored, `resp` at T+7. Assert `rst` during BUS → `wb_cyc`=0 immediately, no `resp`.
- With `SSRV_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, never ack → `wb_cyc` drops after 8 BUS cycles, `resp`=`err`=1. A follow-up read with ack completes with `err`=0.
